// File: rtl/prco_dmem_resp.sv
// prco_dmem_resp
//   Single-port 16-bit data memory with a fixed number of wait states per
//   access and a registered one-cycle completion pulse.
//
//   Parameters
//     ADDR_W      word-address width; the memory holds 2^ADDR_W x 16-bit words
//     WAIT_CYCLES wait states inserted between accepting a request and
//                 performing the access (0..15)
//
//   Ports
//     i_clk    rising-edge clock
//     i_reset  synchronous active-high reset; memory contents are retained
//     i_ce     request strobe, one request per cycle it is sampled high
//     i_we     1 = write, 0 = read (sampled with i_ce)
//     i_addr   16-bit word address (sampled with i_ce)
//     i_din    write data (sampled with i_ce)
//     q_ce     completion pulse, one cycle per accepted request
//     q_dout   read data, qualified by q_ce, held otherwise
//     q_err    address above the memory depth, qualified by q_ce, held otherwise
//     q_busy   high for every wait-state cycle of an in-flight request
//     q_drop   one-cycle pulse after a request arrived during the wait phase
module prco_dmem_resp #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_din,
  output logic        q_ce,
  output logic [15:0] q_dout,
  output logic        q_err,
  output logic        q_busy,
  output logic        q_drop
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request captured at acceptance, used when the access happens later.
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_din;

  // Powers up cleared; never touched by reset.
  logic [15:0] mem [DEPTH] = '{default: '0};

  // Access selection: with no wait states the access uses the live request
  // at its acceptance edge, otherwise the latched request at the last WAIT edge.
  logic              acc_now;
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_din;
  logic              acc_oor;
  logic [ADDR_W-1:0] acc_idx;

  always_comb begin
    acc_now  = 1'b0;
    acc_we   = i_we;
    acc_addr = i_addr;
    acc_din  = i_din;
    if (state == S_WAIT) begin
      acc_now  = (cnt == '0);
      acc_we   = lat_we;
      acc_addr = lat_addr;
      acc_din  = lat_din;
    end else begin
      acc_now  = i_ce && NO_WAIT;
    end
    acc_oor = (acc_addr >> ADDR_W) != '0;
    acc_idx = acc_addr[ADDR_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && acc_now && acc_we && !acc_oor) begin
      mem[acc_idx] <= acc_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      q_ce     <= 1'b0;
      q_err    <= 1'b0;
      q_busy   <= 1'b0;
      q_drop   <= 1'b0;
      q_dout   <= '0;
    end else begin
      q_drop <= (state == S_WAIT) && i_ce;

      if (acc_now) begin
        if (acc_oor) begin
          q_dout <= '0;
          q_err  <= 1'b1;
        end else begin
          q_err <= 1'b0;
          if (!acc_we) begin
            q_dout <= mem[acc_idx];
          end
        end
      end

      unique case (state)
        S_IDLE, S_RESP: begin
          if (i_ce) begin
            lat_we   <= i_we;
            lat_addr <= i_addr;
            lat_din  <= i_din;
            if (NO_WAIT) begin
              state  <= S_RESP;
              q_ce   <= 1'b1;
              q_busy <= 1'b0;
            end else begin
              state  <= S_WAIT;
              cnt    <= CNT_LOAD;
              q_ce   <= 1'b0;
              q_busy <= 1'b1;
            end
          end else begin
            state  <= S_IDLE;
            q_ce   <= 1'b0;
            q_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state  <= S_RESP;
            q_ce   <= 1'b1;
            q_busy <= 1'b0;
          end else begin
            cnt    <= cnt - 4'd1;
            q_ce   <= 1'b0;
            q_busy <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          q_ce   <= 1'b0;
          q_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prco_dmem_resp.sv
module tb_prco_dmem_resp;

  // Three instances: WAIT_CYCLES 0, 1 and 3, all with ADDR_W = 8.
  logic             clk;
  logic [2:0]       rst_v;
  logic [2:0]       ce_v;
  logic [2:0]       we_v;
  logic [2:0][15:0] addr_v;
  logic [2:0][15:0] din_v;
  logic [2:0]       q_ce_v;
  logic [2:0][15:0] q_dout_v;
  logic [2:0]       q_err_v;
  logic [2:0]       q_busy_v;
  logic [2:0]       q_drop_v;

  int n_vec;
  int n_bad;

  prco_dmem_resp #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_reset(rst_v[0]), .i_ce(ce_v[0]), .i_we(we_v[0]),
    .i_addr(addr_v[0]), .i_din(din_v[0]), .q_ce(q_ce_v[0]), .q_dout(q_dout_v[0]),
    .q_err(q_err_v[0]), .q_busy(q_busy_v[0]), .q_drop(q_drop_v[0])
  );
  prco_dmem_resp #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_reset(rst_v[1]), .i_ce(ce_v[1]), .i_we(we_v[1]),
    .i_addr(addr_v[1]), .i_din(din_v[1]), .q_ce(q_ce_v[1]), .q_dout(q_dout_v[1]),
    .q_err(q_err_v[1]), .q_busy(q_busy_v[1]), .q_drop(q_drop_v[1])
  );
  prco_dmem_resp #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
    .i_clk(clk), .i_reset(rst_v[2]), .i_ce(ce_v[2]), .i_we(we_v[2]),
    .i_addr(addr_v[2]), .i_din(din_v[2]), .q_ce(q_ce_v[2]), .q_dout(q_dout_v[2]),
    .q_err(q_err_v[2]), .q_busy(q_busy_v[2]), .q_drop(q_drop_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  // Reference state per instance.
  logic [15:0] ref_mem [3][256];
  logic [15:0] m_dout [3];
  logic        m_err  [3];

  // Stimulus plan (one entry per cycle) and per-cycle expectations.
  logic        s_ce   [256];
  logic        s_we   [256];
  logic [15:0] s_addr [256];
  logic [15:0] s_din  [256];
  logic [19:0] e_vec  [256];   // {q_ce, q_busy, q_drop, q_err, q_dout}

  task automatic clear_stim();
    for (int c = 0; c < 256; c++) begin
      s_ce[c] = 1'b0; s_we[c] = 1'b0; s_addr[c] = '0; s_din[c] = '0;
    end
  endtask

  // Transaction-level model: a request is accepted unless it lands inside the
  // wait window of the previous accepted one; its response appears W+1 cycles
  // later, busy covers the W cycles in between, a refused one pulses drop.
  task automatic plan(input int k, input int n, output int total);
    int          w;
    int          free_at;
    int          r;
    logic        a_val [256];
    logic        a_wr  [256];
    logic [15:0] a_dout[256];
    logic        a_err [256];
    logic        x_ce  [256];
    logic        x_busy[256];
    logic        x_drop[256];
    logic [15:0] hd;
    logic        he;
    w = wc(k);
    total = n + w + 2;
    for (int c = 0; c < 256; c++) begin
      a_val[c] = 1'b0; a_wr[c] = 1'b0; a_dout[c] = '0; a_err[c] = 1'b0;
      x_ce[c] = 1'b0; x_busy[c] = 1'b0; x_drop[c] = 1'b0;
    end
    free_at = 0;
    for (int c = 0; c < n; c++) begin
      if (s_ce[c]) begin
        if (c >= free_at) begin
          r = c + 1 + w;
          x_ce[r] = 1'b1;
          for (int b = c + 1; b <= c + w; b++) x_busy[b] = 1'b1;
          free_at = r;
          a_val[r] = 1'b1;
          if (s_addr[c] > 16'd255) begin
            a_dout[r] = '0;
            a_err[r]  = 1'b1;
          end else if (s_we[c]) begin
            a_wr[r] = 1'b1;
            ref_mem[k][s_addr[c][7:0]] = s_din[c];
          end else begin
            a_dout[r] = ref_mem[k][s_addr[c][7:0]];
          end
        end else begin
          x_drop[c + 1] = 1'b1;
        end
      end
    end
    hd = m_dout[k];
    he = m_err[k];
    for (int c = 0; c <= total; c++) begin
      if (a_val[c]) begin
        if (a_wr[c]) he = 1'b0;
        else begin hd = a_dout[c]; he = a_err[c]; end
      end
      e_vec[c] = {x_ce[c], x_busy[c], x_drop[c], he, hd};
    end
    m_dout[k] = hd;
    m_err[k]  = he;
  endtask

  // Applies stimulus of cycle c to instance k and advances one clock.
  task automatic drive_cycle(input int k, input int c, input int n);
    ce_v[k]   = (c < n) ? s_ce[c] : 1'b0;
    we_v[k]   = s_we[c];
    addr_v[k] = s_addr[c];
    din_v[k]  = s_din[c];
    @(posedge clk); #1;
  endtask

  function automatic logic [19:0] obs(input int k);
    return {q_ce_v[k], q_busy_v[k], q_drop_v[k], q_err_v[k], q_dout_v[k]};
  endfunction

  task automatic test_reset();
    rst_v = '1; ce_v = '0; we_v = '0; addr_v = '0; din_v = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs(k) !== 20'h0) begin
        n_bad++;
        $display("FAIL reset dut%0d {ce,busy,drop,err,dout} got %h exp %h", k, obs(k), 20'h0);
      end
      m_dout[k] = '0;
      m_err[k]  = 1'b0;
    end
    rst_v = '0;
  endtask

  task automatic test_w1_write_read();
    int total;
    clear_stim();
    s_ce[0] = 1; s_we[0] = 1; s_addr[0] = 16'h0005; s_din[0] = 16'h1234;
    s_ce[3] = 1; s_we[3] = 0; s_addr[3] = 16'h0005;
    s_ce[6] = 1; s_we[6] = 0; s_addr[6] = 16'h0100;
    s_ce[9] = 1; s_we[9] = 0; s_addr[9] = 16'h0000;
    plan(1, 10, total);
    for (int c = 0; c <= total; c++) begin
      n_vec++;
      if (obs(1) !== e_vec[c]) begin
        n_bad++;
        $display("FAIL w1_write_read cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(1), e_vec[c]);
      end
      drive_cycle(1, c, 10);
    end
  endtask

  task automatic test_back_to_back();
    int total;
    clear_stim();
    s_ce[0] = 1; s_we[0] = 1; s_addr[0] = 16'h000A; s_din[0] = 16'hBEEF;
    s_ce[1] = 1; s_we[1] = 0; s_addr[1] = 16'h000A;
    s_ce[2] = 1; s_we[2] = 1; s_addr[2] = 16'h000A; s_din[2] = 16'h0001;
    s_ce[3] = 1; s_we[3] = 0; s_addr[3] = 16'h000A;
    plan(0, 4, total);
    for (int c = 0; c <= total; c++) begin
      n_vec++;
      if (obs(0) !== e_vec[c]) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(0), e_vec[c]);
      end
      drive_cycle(0, c, 4);
    end
  endtask

  task automatic test_w3_drop();
    int total;
    clear_stim();
    s_ce[0] = 1; s_we[0] = 0; s_addr[0] = 16'h0003;
    s_ce[1] = 1; s_we[1] = 1; s_addr[1] = 16'h0003; s_din[1] = 16'hFFFF;
    s_ce[6] = 1; s_we[6] = 0; s_addr[6] = 16'h0003;
    plan(2, 7, total);
    for (int c = 0; c <= total; c++) begin
      n_vec++;
      if (obs(2) !== e_vec[c]) begin
        n_bad++;
        $display("FAIL w3_drop cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(2), e_vec[c]);
      end
      drive_cycle(2, c, 7);
    end
  endtask

  task automatic test_reset_abort();
    int          total;
    logic [19:0] exp;
    clear_stim();
    s_ce[0] = 1; s_we[0] = 1; s_addr[0] = 16'h0007; s_din[0] = 16'hA5A5;
    plan(2, 1, total);
    for (int c = 0; c <= total; c++) begin
      n_vec++;
      if (obs(2) !== e_vec[c]) begin
        n_bad++;
        $display("FAIL abort_setup cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(2), e_vec[c]);
      end
      drive_cycle(2, c, 1);
    end
    // Cycle 0: write 0x5555 to 0x07; reset in cycle 2 together with a new i_ce.
    ce_v[2] = 1; we_v[2] = 1; addr_v[2] = 16'h0007; din_v[2] = 16'h5555;
    @(posedge clk); #1;
    for (int c = 1; c <= 7; c++) begin
      exp = (c <= 2) ? {1'b0, 1'b1, 1'b0, m_err[2], m_dout[2]} : 20'h0;
      n_vec++;
      if (obs(2) !== exp) begin
        n_bad++;
        $display("FAIL reset_abort cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(2), exp);
      end
      rst_v[2] = (c == 2);
      ce_v[2]  = (c == 2);
      @(posedge clk); #1;
    end
    m_dout[2] = '0;
    m_err[2]  = 1'b0;
    clear_stim();
    s_ce[0] = 1; s_we[0] = 0; s_addr[0] = 16'h0007;
    plan(2, 1, total);
    for (int c = 0; c <= total; c++) begin
      n_vec++;
      if (obs(2) !== e_vec[c]) begin
        n_bad++;
        $display("FAIL abort_readback cyc%0d {ce,busy,drop,err,dout} got %h exp %h", c, obs(2), e_vec[c]);
      end
      drive_cycle(2, c, 1);
    end
  endtask

  task automatic test_random();
    int total;
    for (int k = 0; k < 3; k++) begin
      clear_stim();
      for (int c = 0; c < 80; c++) begin
        s_ce[c]   = ($urandom % 10) < 7;
        s_we[c]   = $urandom % 2;
        s_addr[c] = (($urandom % 8) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom % 16);
        s_din[c]  = 16'($urandom);
      end
      plan(k, 80, total);
      for (int c = 0; c <= total; c++) begin
        n_vec++;
        if (obs(k) !== e_vec[c]) begin
          n_bad++;
          $display("FAIL random dut%0d cyc%0d {ce,busy,drop,err,dout} got %h exp %h", k, c, obs(k), e_vec[c]);
        end
        drive_cycle(k, c, 80);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) ref_mem[k][a] = '0;
    rst_v = '1; ce_v = '0; we_v = '0; addr_v = '0; din_v = '0;
    test_reset();
    test_w1_write_read();
    test_back_to_back();
    test_w3_drop();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
